// File: rtl/raster_out_formatter.sv
// raster_out_formatter: tracks raster position of the window-center result
// stream, drops results whose 3x3 window was incomplete (first two rows and
// first two columns), tags survivors with sof/eol and buffers them in a small
// FIFO that absorbs downstream backpressure.
module raster_out_formatter #(
    parameter int DATA_WIDTH   = 32,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic                  frame_start,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_sof,
    output logic                  dout_eol,
    output logic                  overflow,
    output logic                  busy
);

    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int RW = $clog2(IMAGE_HEIGHT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam int EW = DATA_WIDTH + 2;

    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [NW-1:0] CNT_FULL = NW'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t          state;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;

    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [NW-1:0]   count;
    logic [NW-1:0]   count_next;

    logic            start;
    logic            active_pix;
    logic            last_col;
    logic            last_row;
    logic            qualified;
    logic            full;
    logic            pop;
    logic            push;
    logic [EW-1:0]   entry;

    // Pixel classification and FIFO handshake decode for the current cycle
    always_comb begin
        start      = din_valid & frame_start;
        // A frame_start pixel is always (0,0) and therefore never qualified
        active_pix = din_valid & (state == ACTIVE) & ~frame_start;
        last_col   = (col == COL_LAST);
        last_row   = (row == ROW_LAST);
        qualified  = active_pix & (row >= ROW_TWO) & (col >= COL_TWO);
        entry      = {(row == ROW_TWO) && (col == COL_TWO), last_col, din};
        full       = (count == CNT_FULL);
        pop        = dout_valid & dout_ready;
        push       = qualified & (~full | pop);
        count_next = count;
        if (push && !pop) begin
            count_next = count + NW'(1);
        end else if (pop && !push) begin
            count_next = count - NW'(1);
        end
    end

    // Frame FSM with raster counters; busy is registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            // Start or restart: this pixel is (0,0), so the next one is (0,1)
            state <= ACTIVE;
            busy  <= 1'b1;
            col   <= CW'(1);
            row   <= '0;
        end else if (active_pix) begin
            if (last_col) begin
                col <= '0;
                if (last_row) begin
                    row   <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    row <= row + RW'(1);
                end
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Sticky overflow: set on a dropped qualified pixel, cleared by frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (start) begin
            overflow <= 1'b0;
        end else if (qualified && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    // Output FIFO storage, pointers, occupancy and registered valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dout_valid <= 1'b0;
        end else begin
            // When full, a write is only allowed with a pop; it lands in the
            // slot being read out this same cycle, which is already consumed.
            if (push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count      <= count_next;
            dout_valid <= (count_next != '0);
        end
    end

    // Head entry drives the outputs straight from storage registers
    always_comb begin
        {dout_sof, dout_eol, dout} = mem[rd_ptr];
    end

endmodule
